// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared widths, ROB entry layout and free-eligibility predicate
// Purpose: common types for retire_rob, its interface and its sub-modules.
//   PREG_W  physical register index width
//   AREG_W  architectural register index width
//   rob_entry_t  {valid, done, regwrite, rd, olddest}
//   free_eligible()  true when a retiring entry returns olddest to the free pool
package rob_pkg;
   localparam int PREG_W = 7;
   localparam int AREG_W = 5;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              regwrite;
      logic [AREG_W-1:0] rd;
      logic [PREG_W-1:0] olddest;
   } rob_entry_t;

   // p0 is hard-wired and never enters the free pool, and x0 writes never
   // displaced a real mapping.
   function automatic logic free_eligible(input rob_entry_t e);
      return e.regwrite && (e.rd != '0) && (e.olddest != '0);
   endfunction
endpackage

// File: rtl/retire_rob_if.sv
// rtl/retire_rob_if.sv - rename/execute/free-pool signal bundle of the ROB
// Purpose: groups every ROB port except clk/reset.
//   alloc_*  rename -> ROB allocation (two slots), alloc_ready/alloc_tag_n back
//   cmpl_*   execute -> ROB completion strobes and tags
//   free_valid_n/freereg_n, retire_count, rob_count, rob_empty  ROB -> core
//   flush    squash all entries (only when ROB_FLUSH_EN is defined)
// Modports: slave = ROB side, master = driver side.
interface retire_rob_if #(
   parameter int DEPTH = 16
);
   import rob_pkg::*;
   localparam int TAG_W = $clog2(DEPTH);

   logic              alloc_valid_1, alloc_valid_2;
   logic              alloc_regwrite_1, alloc_regwrite_2;
   logic [AREG_W-1:0] alloc_rd_1, alloc_rd_2;
   logic [PREG_W-1:0] alloc_olddest_1, alloc_olddest_2;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag_1, alloc_tag_2;
   logic              cmpl_valid_1, cmpl_valid_2;
   logic [TAG_W-1:0]  cmpl_tag_1, cmpl_tag_2;
   logic              free_valid_1, free_valid_2;
   logic [PREG_W-1:0] freereg_1, freereg_2;
   logic [1:0]        retire_count;
   logic [TAG_W:0]    rob_count;
   logic              rob_empty;
`ifdef ROB_FLUSH_EN
   logic              flush;
`endif

   modport slave (
`ifdef ROB_FLUSH_EN
      input  flush,
`endif
      input  alloc_valid_1, alloc_valid_2, alloc_regwrite_1, alloc_regwrite_2,
      input  alloc_rd_1, alloc_rd_2, alloc_olddest_1, alloc_olddest_2,
      input  cmpl_valid_1, cmpl_valid_2, cmpl_tag_1, cmpl_tag_2,
      output alloc_ready, alloc_tag_1, alloc_tag_2,
      output free_valid_1, free_valid_2, freereg_1, freereg_2,
      output retire_count, rob_count, rob_empty
   );

   modport master (
`ifdef ROB_FLUSH_EN
      output flush,
`endif
      output alloc_valid_1, alloc_valid_2, alloc_regwrite_1, alloc_regwrite_2,
      output alloc_rd_1, alloc_rd_2, alloc_olddest_1, alloc_olddest_2,
      output cmpl_valid_1, cmpl_valid_2, cmpl_tag_1, cmpl_tag_2,
      input  alloc_ready, alloc_tag_1, alloc_tag_2,
      input  free_valid_1, free_valid_2, freereg_1, freereg_2,
      input  retire_count, rob_count, rob_empty
   );
endinterface

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrap-bit circular pointer with +0/+1/+2 step and load
// Purpose: head/tail pointer of the ROB; MSB is the wrap bit.
//   clk, reset  clock, async active-high reset (pointer -> 0)
//   i_inc       step 0..2
//   i_load      load i_load_val instead of stepping
//   o_ptr       current pointer, TAG_W+1 bits
module rob_ptr #(
   parameter int TAG_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     i_inc,
   input  logic           i_load,
   input  logic [TAG_W:0] i_load_val,
   output logic [TAG_W:0] o_ptr
);
   logic [TAG_W:0] r_ptr;

   // DEPTH is a power of two, so plain binary overflow of the low bits
   // toggles the wrap bit exactly at the buffer boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_load_val;
      end else begin
         r_ptr <= r_ptr + (TAG_W+1)'(i_inc);
      end
   end

   assign o_ptr = r_ptr;
endmodule

// File: rtl/retire_rob.sv
// rtl/retire_rob.sv - 2-wide reorder buffer with in-order retire and preg free
// Purpose: allocates up to two entries per cycle, marks completions, retires
// up to two done entries in order and returns their old pregs.
//   clk, reset  clock, async active-high reset
//   rob         retire_rob_if.slave (alloc, completion, free, status)
// Optional: ROB_FLUSH_EN adds rob.flush, which squashes every entry.
module retire_rob
   import rob_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input logic         clk,
   input logic         reset,
   retire_rob_if.slave rob
);
   localparam int TAG_W = $clog2(DEPTH);

   logic [TAG_W:0]    w_head, w_tail, w_count;
   logic [TAG_W-1:0]  w_head_idx, w_head_idx1, w_tail_idx, w_tail_idx1;
   logic              w_flush, w_ready;
   logic              w_alloc_1, w_alloc_2, w_ret_1, w_ret_2, w_free_1, w_free_2;
   logic [1:0]        w_alloc_inc, w_ret_inc;
   rob_entry_t        w_head_e, w_head_e1;

   logic [DEPTH-1:0]  r_valid, r_done;
   logic              r_regwrite [DEPTH];
   logic [AREG_W-1:0] r_rd       [DEPTH];
   logic [PREG_W-1:0] r_olddest  [DEPTH];

   logic              r_free_valid_1, r_free_valid_2;
   logic [PREG_W-1:0] r_freereg_1, r_freereg_2;
   logic [1:0]        r_retire_count;

`ifdef ROB_FLUSH_EN
   assign w_flush = rob.flush;
`else
   assign w_flush = 1'b0;
`endif

   // Occupancy comes from the pointers; the wrap bit disambiguates full/empty.
   assign w_count     = w_tail - w_head;
   assign w_ready     = (w_count <= (TAG_W+1)'(DEPTH - 2));
   assign w_head_idx  = w_head[TAG_W-1:0];
   assign w_head_idx1 = w_head_idx + TAG_W'(1);
   assign w_tail_idx  = w_tail[TAG_W-1:0];
   assign w_tail_idx1 = w_tail_idx + TAG_W'(1);

   always_comb begin
      w_head_e  = '{valid: r_valid[w_head_idx], done: r_done[w_head_idx],
                    regwrite: r_regwrite[w_head_idx], rd: r_rd[w_head_idx],
                    olddest: r_olddest[w_head_idx]};
      w_head_e1 = '{valid: r_valid[w_head_idx1], done: r_done[w_head_idx1],
                    regwrite: r_regwrite[w_head_idx1], rd: r_rd[w_head_idx1],
                    olddest: r_olddest[w_head_idx1]};
   end

   // Allocation is not credited with same-cycle retires: ready uses the
   // registered count only.
   assign w_alloc_1   = w_ready && rob.alloc_valid_1 && !w_flush;
   assign w_alloc_2   = w_alloc_1 && rob.alloc_valid_2;
   assign w_ret_1     = !w_flush && w_head_e.valid && w_head_e.done;
   assign w_ret_2     = w_ret_1 && w_head_e1.valid && w_head_e1.done;
   assign w_free_1    = w_ret_1 && free_eligible(w_head_e);
   assign w_free_2    = w_ret_2 && free_eligible(w_head_e1);
   assign w_alloc_inc = {1'b0, w_alloc_1} + {1'b0, w_alloc_2};
   assign w_ret_inc   = {1'b0, w_ret_1} + {1'b0, w_ret_2};

   rob_ptr #(.TAG_W(TAG_W)) u_head (
      .clk        (clk),
      .reset      (reset),
      .i_inc      (w_ret_inc),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_ptr      (w_head)
   );

   // A flush collapses the buffer by pulling tail back onto head.
   rob_ptr #(.TAG_W(TAG_W)) u_tail (
      .clk        (clk),
      .reset      (reset),
      .i_inc      (w_alloc_inc),
      .i_load     (w_flush),
      .i_load_val (w_head),
      .o_ptr      (w_tail)
   );

   // Ordering inside the else-branch matters: completion, then retire
   // invalidation, then allocation. Allocation only ever targets free slots,
   // so a completion aimed at a slot being allocated sees valid=0 and is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid        <= '0;
         r_done         <= '0;
         r_free_valid_1 <= 1'b0;
         r_free_valid_2 <= 1'b0;
         r_freereg_1    <= '0;
         r_freereg_2    <= '0;
         r_retire_count <= '0;
      end else begin
         r_retire_count <= w_ret_inc;
         r_free_valid_1 <= w_free_1;
         r_free_valid_2 <= w_free_2;
         r_freereg_1    <= w_free_1 ? w_head_e.olddest  : '0;
         r_freereg_2    <= w_free_2 ? w_head_e1.olddest : '0;
         if (w_flush) begin
            r_valid <= '0;
            r_done  <= '0;
         end else begin
            if (rob.cmpl_valid_1 && r_valid[rob.cmpl_tag_1]) r_done[rob.cmpl_tag_1] <= 1'b1;
            if (rob.cmpl_valid_2 && r_valid[rob.cmpl_tag_2]) r_done[rob.cmpl_tag_2] <= 1'b1;
            if (w_ret_1) r_valid[w_head_idx]  <= 1'b0;
            if (w_ret_2) r_valid[w_head_idx1] <= 1'b0;
            if (w_alloc_1) begin
               r_valid[w_tail_idx] <= 1'b1;
               r_done[w_tail_idx]  <= 1'b0;
            end
            if (w_alloc_2) begin
               r_valid[w_tail_idx1] <= 1'b1;
               r_done[w_tail_idx1]  <= 1'b0;
            end
         end
      end
   end

   // Payload is qualified by r_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_alloc_1) begin
         r_regwrite[w_tail_idx] <= rob.alloc_regwrite_1;
         r_rd[w_tail_idx]       <= rob.alloc_rd_1;
         r_olddest[w_tail_idx]  <= rob.alloc_olddest_1;
      end
      if (w_alloc_2) begin
         r_regwrite[w_tail_idx1] <= rob.alloc_regwrite_2;
         r_rd[w_tail_idx1]       <= rob.alloc_rd_2;
         r_olddest[w_tail_idx1]  <= rob.alloc_olddest_2;
      end
   end

   assign rob.alloc_ready  = w_ready;
   assign rob.alloc_tag_1  = w_tail_idx;
   assign rob.alloc_tag_2  = w_tail_idx1;
   assign rob.free_valid_1 = r_free_valid_1;
   assign rob.free_valid_2 = r_free_valid_2;
   assign rob.freereg_1    = r_freereg_1;
   assign rob.freereg_2    = r_freereg_2;
   assign rob.retire_count = r_retire_count;
   assign rob.rob_count    = w_count;
   assign rob.rob_empty    = (w_count == '0);
endmodule

// File: tb/tb_retire_rob.sv
// tb/tb_retire_rob.sv - random + directed bench for retire_rob against a queue model
module tb_retire_rob;
   localparam int DEPTH = 16;

   typedef struct {
      int tag;
      bit rw;
      int rd;
      int od;
      bit done;
   } mrec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   retire_rob_if #(.DEPTH(DEPTH)) bus ();

   retire_rob #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .rob   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_free_seen = 0;
   int n_ret_seen = 0;

   mrec_t q[$];
   int next_tag = 0;
   int e_fv1, e_fv2, e_fr1, e_fr2, e_rc;

   logic       s_av1, s_av2, s_rw1, s_rw2, s_cv1, s_cv2, s_fl;
   logic [4:0] s_rd1, s_rd2;
   logic [6:0] s_od1, s_od2;
   logic [3:0] s_ct1, s_ct2;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_stim();
      s_av1 = 0; s_av2 = 0; s_rw1 = 0; s_rw2 = 0; s_cv1 = 0; s_cv2 = 0; s_fl = 0;
      s_rd1 = 0; s_rd2 = 0; s_od1 = 0; s_od2 = 0; s_ct1 = 0; s_ct2 = 0;
   endtask

   task automatic drive();
      bus.alloc_valid_1 = s_av1;     bus.alloc_valid_2 = s_av2;
      bus.alloc_regwrite_1 = s_rw1;  bus.alloc_regwrite_2 = s_rw2;
      bus.alloc_rd_1 = s_rd1;        bus.alloc_rd_2 = s_rd2;
      bus.alloc_olddest_1 = s_od1;   bus.alloc_olddest_2 = s_od2;
      bus.cmpl_valid_1 = s_cv1;      bus.cmpl_valid_2 = s_cv2;
      bus.cmpl_tag_1 = s_ct1;        bus.cmpl_tag_2 = s_ct2;
`ifdef ROB_FLUSH_EN
      bus.flush = s_fl;
`endif
   endtask

   task automatic check_outputs();
      chk("rob_count", int'(bus.rob_count), q.size());
      chk("rob_empty", int'(bus.rob_empty), int'(q.size() == 0));
      chk("alloc_ready", int'(bus.alloc_ready), int'(q.size() <= DEPTH - 2));
      chk("alloc_tag_1", int'(bus.alloc_tag_1), next_tag);
      chk("alloc_tag_2", int'(bus.alloc_tag_2), (next_tag + 1) % DEPTH);
      chk("retire_count", int'(bus.retire_count), e_rc);
      chk("free_valid_1", int'(bus.free_valid_1), e_fv1);
      chk("freereg_1", int'(bus.freereg_1), e_fr1);
      chk("free_valid_2", int'(bus.free_valid_2), e_fv2);
      chk("freereg_2", int'(bus.freereg_2), e_fr2);
      n_free_seen += int'(bus.free_valid_1) + int'(bus.free_valid_2);
      n_ret_seen  += int'(bus.retire_count);
   endtask

   // Program-order model: the queue front is the oldest instruction.
   task automatic model_step();
      int sz = q.size();
      int n = 0;
      bit ready = (sz <= DEPTH - 2);
      mrec_t r;
      e_fv1 = 0; e_fv2 = 0; e_fr1 = 0; e_fr2 = 0; e_rc = 0;
      if (s_fl) begin
         next_tag = (next_tag - sz + DEPTH) % DEPTH;
         q.delete();
         return;
      end
      if (sz > 0 && q[0].done) n = 1;
      if (n == 1 && sz > 1 && q[1].done) n = 2;
      e_rc = n;
      if (n >= 1 && q[0].rw && q[0].rd != 0 && q[0].od != 0) begin e_fv1 = 1; e_fr1 = q[0].od; end
      if (n == 2 && q[1].rw && q[1].rd != 0 && q[1].od != 0) begin e_fv2 = 1; e_fr2 = q[1].od; end
      foreach (q[i]) begin
         if (s_cv1 && q[i].tag == int'(s_ct1)) q[i].done = 1;
         if (s_cv2 && q[i].tag == int'(s_ct2)) q[i].done = 1;
      end
      repeat (n) void'(q.pop_front());
      if (ready && s_av1) begin
         r = '{tag: next_tag, rw: s_rw1, rd: int'(s_rd1), od: int'(s_od1), done: 0};
         q.push_back(r);
         next_tag = (next_tag + 1) % DEPTH;
         if (s_av2) begin
            r = '{tag: next_tag, rw: s_rw2, rd: int'(s_rd2), od: int'(s_od2), done: 0};
            q.push_back(r);
            next_tag = (next_tag + 1) % DEPTH;
         end
      end
   endtask

   task automatic step();
      check_outputs();
      drive();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_stim();
      drive();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      q.delete();
      next_tag = 0;
      e_fv1 = 0; e_fv2 = 0; e_fr1 = 0; e_fr2 = 0; e_rc = 0;
   endtask

   function automatic int pick_pending();
      int p[$];
      foreach (q[i]) if (!q[i].done) p.push_back(q[i].tag);
      if (p.size() == 0) return -1;
      return p[$urandom_range(0, p.size() - 1)];
   endfunction

   task automatic rand_cmpl_port(output logic cv, output logic [3:0] ct);
      int r = $urandom_range(0, 9);
      int t = pick_pending();
      cv = 0;
      ct = 0;
      if (r < 6 && t >= 0) begin
         cv = 1; ct = 4'(t);
      end else if (r < 8) begin
         cv = 1; ct = 4'($urandom_range(0, DEPTH - 1));
      end
   endtask

   task automatic rand_stim();
      s_av1 = ($urandom_range(0, 3) != 0);
      s_av2 = $urandom_range(0, 1) != 0;
      s_rw1 = ($urandom_range(0, 4) != 0);
      s_rw2 = ($urandom_range(0, 4) != 0);
      s_rd1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s_rd2 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      s_od1 = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      s_od2 = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      rand_cmpl_port(s_cv1, s_ct1);
      rand_cmpl_port(s_cv2, s_ct2);
      s_fl = 0;
`ifdef ROB_FLUSH_EN
      s_fl = ($urandom_range(0, 39) == 0);
`endif
   endtask

   initial begin
      int prev;
      int head_tag;
      idle_stim();
      drive();
      e_fv1 = 0; e_fv2 = 0; e_fr1 = 0; e_fr2 = 0; e_rc = 0;
      #12;
      @(negedge clk);
      reset = 1'b0;

      // Pair retires together only once the older entry completes.
      idle_stim();
      s_av1 = 1; s_av2 = 1; s_rw1 = 1; s_rw2 = 1;
      s_rd1 = 5; s_od1 = 5; s_rd2 = 6; s_od2 = 6;
      step();
      idle_stim(); s_cv1 = 1; s_ct1 = 4'd1; step();
      idle_stim(); s_cv1 = 1; s_ct1 = 4'd0; step();
      idle_stim(); step();
      chk("pair_fv1", int'(bus.free_valid_1), 1);
      chk("pair_fr1", int'(bus.freereg_1), 5);
      chk("pair_fv2", int'(bus.free_valid_2), 1);
      chk("pair_fr2", int'(bus.freereg_2), 6);
      chk("pair_rc", int'(bus.retire_count), 2);
      step();

      // Fill to capacity; extra alloc is dropped.
      do_reset();
      repeat (8) begin
         idle_stim();
         s_av1 = 1; s_av2 = 1; s_rw1 = 1; s_rw2 = 1;
         s_rd1 = 5'($urandom_range(1, 31)); s_od1 = 7'($urandom_range(1, 127));
         s_rd2 = 5'($urandom_range(1, 31)); s_od2 = 7'($urandom_range(1, 127));
         step();
      end
      chk("full_count", int'(bus.rob_count), 16);
      chk("full_ready", int'(bus.alloc_ready), 0);
      idle_stim(); s_av1 = 1; s_rw1 = 1; s_rd1 = 3; s_od1 = 3; step();
      chk("full_drop", int'(bus.rob_count), 16);
      for (int i = 0; i < 80 && q.size() != 0; i++) begin
         idle_stim();
         rand_cmpl_port(s_cv1, s_ct1);
         rand_cmpl_port(s_cv2, s_ct2);
         step();
      end
      idle_stim(); step(); step();
      chk("drain_empty", int'(bus.rob_empty), 1);

      // Entries that must not free anything.
      do_reset();
      n_free_seen = 0; n_ret_seen = 0;
      idle_stim();
      s_av1 = 1; s_av2 = 1; s_rw1 = 1; s_rd1 = 0; s_od1 = 9; s_rw2 = 1; s_rd2 = 3; s_od2 = 0;
      step();
      idle_stim();
      s_av1 = 1; s_rw1 = 0; s_rd1 = 4; s_od1 = 4;
      s_cv1 = 1; s_ct1 = 4'd0; s_cv2 = 1; s_ct2 = 4'd1;
      step();
      idle_stim(); s_cv1 = 1; s_ct1 = 4'd2; step();
      idle_stim(); repeat (3) step();
      chk("p0_no_free", n_free_seen, 0);
      chk("p0_retired", n_ret_seen, 3);

      // Steady single alloc with next-cycle completion across several wraps.
      do_reset();
      n_free_seen = 0;
      prev = 0;
      for (int i = 0; i < 40; i++) begin
         idle_stim();
         s_av1 = 1; s_rw1 = 1; s_rd1 = 5'(1 + i % 31); s_od1 = 7'(1 + i);
         s_cv1 = (i > 0); s_ct1 = 4'(prev);
         prev = next_tag;
         step();
      end
      idle_stim(); s_cv1 = 1; s_ct1 = 4'(prev); step();
      idle_stim(); repeat (4) step();
      chk("wrap_frees", n_free_seen, 40);
      chk("wrap_tail", int'(bus.alloc_tag_1), 40 % DEPTH);

`ifdef ROB_FLUSH_EN
      // Squash six entries, two of them done but not at head.
      n_free_seen = 0;
      repeat (3) begin
         idle_stim();
         s_av1 = 1; s_av2 = 1; s_rw1 = 1; s_rw2 = 1;
         s_rd1 = 7; s_od1 = 70; s_rd2 = 8; s_od2 = 80;
         step();
      end
      head_tag = q[0].tag;
      idle_stim(); s_cv1 = 1; s_ct1 = 4'(q[2].tag); s_cv2 = 1; s_ct2 = 4'(q[3].tag); step();
      idle_stim(); s_fl = 1; step();
      idle_stim(); step();
      chk("flush_count", int'(bus.rob_count), 0);
      chk("flush_tag", int'(bus.alloc_tag_1), head_tag);
      chk("flush_no_free", n_free_seen, 0);
`else
      head_tag = 0;
`endif

      // Reset while five entries are in flight.
      idle_stim();
      s_av1 = 1; s_av2 = 1; s_rw1 = 1; s_rw2 = 1; s_rd1 = 9; s_od1 = 19; s_rd2 = 10; s_od2 = 20;
      step(); step();
      s_av2 = 0; step();
      do_reset();
      n_free_seen = 0;
      chk("rst_empty", int'(bus.rob_empty), 1);
      idle_stim(); step(); step();
      chk("rst_no_free", n_free_seen, head_tag * 0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
            @(negedge clk);
         end else begin
            rand_stim();
            step();
         end
      end
      idle_stim();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
